// File: rtl/abcde_step_sequencer.sv
// Staircase stimulus sequencer for the a..e assertion lines: runs P passes of 5 cumulative steps, each held H+1 clocks.
// Optional macro ABCDE_SEQ_STATUS_EN adds a saturating busy-cycle counter output (cycle_count).
module abcde_step_sequencer #(
  parameter int HOLD_W = 4,
  parameter int REP_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [REP_W-1:0]  repeat_cnt,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              pause,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  pass_idx
`ifdef ABCDE_SEQ_STATUS_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_step, w_step_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [HOLD_W-1:0] r_hlim, w_hlim_nxt;
  logic [REP_W-1:0]  r_pass, w_pass_nxt;
  logic [REP_W-1:0]  r_last, w_last_nxt;
  logic [4:0]        r_lines, w_lines_nxt;
  logic              r_busy, r_done, w_done_nxt;
  logic              w_start_acc;

  assign w_start_acc = (r_state == S_IDLE) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_hold  <= '0;
      r_hlim  <= '0;
      r_pass  <= '0;
      r_last  <= '0;
      r_lines <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_hold  <= w_hold_nxt;
      r_hlim  <= w_hlim_nxt;
      r_pass  <= w_pass_nxt;
      r_last  <= w_last_nxt;
      r_lines <= w_lines_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_hold_nxt  = r_hold;
    w_hlim_nxt  = r_hlim;
    w_pass_nxt  = r_pass;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_step_nxt  = 3'd1;
          w_hold_nxt  = '0;
          w_pass_nxt  = '0;
          // Keep P-1 so a zero repeat count collapses to a single pass
          w_last_nxt  = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
          w_hlim_nxt  = hold_cycles;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_step_nxt  = '0;
          w_hold_nxt  = '0;
          w_pass_nxt  = '0;
        end else if (!pause) begin
          if (r_hold != r_hlim) begin
            w_hold_nxt = r_hold + 1'b1;
          end else begin
            w_hold_nxt = '0;
            if (r_step != 3'd5) begin
              w_step_nxt = r_step + 3'd1;
            end else if (r_pass != r_last) begin
              w_step_nxt = 3'd1;
              w_pass_nxt = r_pass + 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_step_nxt  = '0;
              w_pass_nxt  = '0;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_lines_nxt = 5'b00000;
    case (w_step_nxt)
      3'd1:    w_lines_nxt = 5'b00001;
      3'd2:    w_lines_nxt = 5'b00011;
      3'd3:    w_lines_nxt = 5'b00111;
      3'd4:    w_lines_nxt = 5'b01111;
      3'd5:    w_lines_nxt = 5'b11111;
      default: w_lines_nxt = 5'b00000;
    endcase
  end

  assign a        = r_lines[0];
  assign b        = r_lines[1];
  assign c        = r_lines[2];
  assign d        = r_lines[3];
  assign e        = r_lines[4];
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass_idx = r_pass;

`ifdef ABCDE_SEQ_STATUS_EN
  logic [15:0] r_cyc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cyc <= '0;
    end else if (w_start_acc) begin
      r_cyc <= '0;
    end else if (r_busy && (r_cyc != 16'hFFFF)) begin
      r_cyc <= r_cyc + 16'd1;
    end
  end

  assign cycle_count = r_cyc;
`endif

endmodule

// File: tb/tb_abcde_step_sequencer.sv
// Directed bench for abcde_step_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_abcde_step_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] repeat_cnt = '0;
  logic [3:0] hold_cycles = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       a, b, c, d, e, busy, done;
  logic [3:0] pass_idx;
`ifdef ABCDE_SEQ_STATUS_EN
  logic [15:0] cycle_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  abcde_step_sequencer #(.HOLD_W(4), .REP_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .repeat_cnt  (repeat_cnt),
    .hold_cycles (hold_cycles),
    .pause       (pause),
    .abort       (abort),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .busy        (busy),
    .done        (done),
    .pass_idx    (pass_idx)
`ifdef ABCDE_SEQ_STATUS_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  wire [4:0] lines = {e, d, c, b, a};

  typedef struct {
    logic       st;
    logic       pa;
    logic       ab;
    logic [3:0] rep;
    logic [3:0] hold;
    logic [4:0] x_lines;
    logic       x_busy;
    logic       x_done;
    logic [3:0] x_pass;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mkv(input logic st, input logic pa, input logic ab,
                               input logic [3:0] rep, input logic [3:0] hold,
                               input logic [4:0] xl, input logic xb, input logic xd,
                               input logic [3:0] xp);
    vec_t v;
    v.st = st; v.pa = pa; v.ab = ab; v.rep = rep; v.hold = hold;
    v.x_lines = xl; v.x_busy = xb; v.x_done = xd; v.x_pass = xp;
    return v;
  endfunction

  function automatic logic [4:0] stair(input int k);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < k; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Start a run and check every busy cycle against the staircase model.
  task automatic run_check(input string nm, input logic [3:0] rep, input logic [3:0] hold,
                           input int exp_busy);
    int idx;
    int h1;
    bit seen;
    idx = 0;
    seen = 0;
    h1 = int'(hold) + 1;
    repeat_cnt = rep;
    hold_cycles = hold;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (busy) begin
        chk({nm, "_lines"}, 32'(lines), 32'(stair((idx / h1) % 5 + 1)));
        chk({nm, "_pass"}, 32'(pass_idx), idx / (5 * h1));
        chk({nm, "_done_in_busy"}, 32'(done), 0);
        idx++;
      end else if (done) begin
        seen = 1;
      end else begin
        chk({nm, "_idle_gap"}, 32'(busy), 1);
      end
      if (!seen) step();
    end
    chk({nm, "_done_seen"}, 32'(seen), 1);
    chk({nm, "_busy_cycles"}, idx, exp_busy);
    chk({nm, "_done_lines"}, 32'({lines, pass_idx}), 0);
`ifdef ABCDE_SEQ_STATUS_EN
    chk({nm, "_cycle_count"}, 32'(cycle_count), exp_busy);
`endif
    step();
    chk({nm, "_done_pulse_len"}, 32'(done), 0);
  endtask

  initial begin
    // pause-during-pass0-step3 run, idle corner cases, start+abort in idle
    vt[0]  = mkv(1, 0, 0, 4'd2, 4'd0, 5'b00001, 1, 0, 0);
    vt[1]  = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00011, 1, 0, 0);
    vt[2]  = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 0);
    vt[3]  = mkv(0, 1, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 0);
    vt[4]  = mkv(0, 1, 0, 4'd9, 4'd0, 5'b00111, 1, 0, 0);
    vt[5]  = mkv(0, 1, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 0);
    vt[6]  = mkv(0, 1, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 0);
    vt[7]  = mkv(0, 0, 0, 4'd0, 4'd0, 5'b01111, 1, 0, 0);
    vt[8]  = mkv(0, 0, 0, 4'd0, 4'd0, 5'b11111, 1, 0, 0);
    vt[9]  = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00001, 1, 0, 1);
    vt[10] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00011, 1, 0, 1);
    vt[11] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 1);
    vt[12] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b01111, 1, 0, 1);
    vt[13] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b11111, 1, 0, 1);
    vt[14] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00000, 0, 1, 0);
    vt[15] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00000, 0, 0, 0);
    vt[16] = mkv(0, 1, 1, 4'd0, 4'd0, 5'b00000, 0, 0, 0);
    vt[17] = mkv(1, 0, 1, 4'd0, 4'd0, 5'b00001, 1, 0, 0);
    vt[18] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00011, 1, 0, 0);
    vt[19] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00111, 1, 0, 0);
    vt[20] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b01111, 1, 0, 0);
    vt[21] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b11111, 1, 0, 0);
    vt[22] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00000, 0, 1, 0);
    vt[23] = mkv(0, 0, 0, 4'd0, 4'd0, 5'b00000, 0, 0, 0);

    // reset state
    step();
    step();
    chk("reset_outputs", 32'({lines, busy, done, pass_idx}), 0);
    reset = 1'b0;
    step();
    step();
    chk("post_reset_idle", 32'({lines, busy, done, pass_idx}), 0);

    for (int i = 0; i < 24; i++) begin
      start = vt[i].st; pause = vt[i].pa; abort = vt[i].ab;
      repeat_cnt = vt[i].rep; hold_cycles = vt[i].hold;
      step();
      chk($sformatf("vec%0d_lines", i), 32'(lines), 32'(vt[i].x_lines));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].x_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].x_done));
      chk($sformatf("vec%0d_pass", i), 32'(pass_idx), 32'(vt[i].x_pass));
`ifdef ABCDE_SEQ_STATUS_EN
      if (i == 14) chk("vec14_cycle_count", 32'(cycle_count), 14);
      if (i == 22) chk("vec22_cycle_count", 32'(cycle_count), 5);
`endif
    end
    start = 0; pause = 0; abort = 0;

    run_check("rep5_h0", 4'd5, 4'd0, 25);
    run_check("rep0_h2", 4'd0, 4'd2, 15);

    // abort during pass1 step4 with pause high
    repeat_cnt = 4'd3; hold_cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    chk("pre_abort_lines", 32'(lines), 32'(5'b01111));
    chk("pre_abort_pass", 32'(pass_idx), 1);
    abort = 1'b1; pause = 1'b1;
    step();
    abort = 1'b0; pause = 1'b0;
    chk("abort_outputs", 32'({lines, busy, done, pass_idx}), 0);
    repeat (3) begin
      step();
      chk("abort_no_done", 32'({busy, done}), 0);
    end
`ifdef ABCDE_SEQ_STATUS_EN
    chk("abort_cycle_count_hold", 32'(cycle_count), 17);
`endif
    run_check("after_abort", 4'd1, 4'd0, 5);

    // start while busy ignored, then start in the done cycle
    repeat_cnt = 4'd1; hold_cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat_cnt = 4'd9; hold_cycles = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_lines", 32'(lines), 32'(5'b00011));
    repeat (7) step();
    chk("busy_start_last", 32'({lines, busy, pass_idx}), 32'({5'b11111, 1'b1, 4'd0}));
    step();
    chk("busy_start_done", 32'({busy, done}), 32'(2'b01));
    repeat_cnt = 4'd1; hold_cycles = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("done_cycle_start", 32'({lines, busy, done}), 32'({5'b00001, 1'b1, 1'b0}));
    repeat (4) step();
    chk("done_cycle_run_end", 32'(lines), 32'(5'b11111));
    step();
    chk("done_cycle_run_done", 32'(done), 1);

    // asynchronous reset between edges
    repeat_cnt = 4'd3; hold_cycles = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("pre_reset_pass", 32'({lines, pass_idx}), 32'({5'b00111, 4'd1}));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({lines, busy, done, pass_idx}), 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (3) step();
    chk("post_async_reset_idle", 32'({lines, busy, done}), 0);
`ifdef ABCDE_SEQ_STATUS_EN
    chk("reset_cycle_count", 32'(cycle_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
